fifo_level: RTL and testbench

Parametrised synchronous FIFO, the successor to the team's basic FWFT FIFO. It adds three things: arbitrary (non-power-of-two) depth, an occupancy count with almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It sits between a streaming producer and consumer in one clock domain and stores data in the existing `bram` macro. FWFT and standard read modes are both selected by parameter.

---
 rtl/fifo_pkg.sv | 34 +++
 rtl/fifo_level_if.sv | 40 ++++
 rtl/bram.sv | 42 ++++
 rtl/fifo_level.sv | 166 ++++++++++++++++
 tb/tb_fifo_level.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkg
//  Purpose  : Shared widths, pointer-wrap helper and read-mode enum for the
//             fifo_level FIFO family.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int CNT_W(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer addresses 0..depth-1; depth >= 2 keeps this at least 1 bit.
    function automatic int PTR_W(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Explicit wrap so non-power-of-two depths address only valid entries.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int depth);
        if (ptr == 32'(depth - 1)) begin
            return 32'd0;
        end
        return ptr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_level_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_level_if
//  Purpose  : Producer/consumer bundle of the fifo_level FIFO. The master
//             modport is the user side, the slave modport is the FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
interface fifo_level_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
);
    localparam int CW = fifo_pkg::CNT_W(DEPTH);

    logic             wr;
    logic [WIDTH-1:0] din;
    logic             full;
    logic             rd;
    logic             empty;
    logic [WIDTH-1:0] dout;
    logic             dvld;
    logic [CW-1:0]    count;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr, din, rd,
        input  full, empty, dout, dvld, count,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  wr, din, rd,
        output full, empty, dout, dvld, count,
               almost_full, almost_empty, overflow, underflow
    );

endinterface
`default_nettype wire

// File: rtl/bram.sv
`default_nettype none
// ============================================================================
//  Module   : bram
//  Purpose  : Simple dual-port RAM: port A write, port B synchronous read
//             with enable. Read register holds when not enabled.
//  Revision : 1.1 - synchronous reset on the read register
// ============================================================================
module bram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             we_a,
    input  wire logic [AW-1:0]    addr_a,
    input  wire logic [WIDTH-1:0] din_a,
    input  wire logic             en_b,
    input  wire logic [AW-1:0]    addr_b,
    output logic      [WIDTH-1:0] dout_b
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Port A write.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= din_a;
        end
    end

    // Port B registered read; output holds between enabled reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_b <= '0;
        end else if (en_b) begin
            dout_b <= mem[addr_b];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_level.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_level
//  Purpose  : Single-clock FIFO of arbitrary depth with occupancy count,
//             almost-full/almost-empty thresholds, sticky overflow/underflow
//             flags and selectable FWFT or standard read mode.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_level
    import fifo_pkg::*;
#(
    parameter int FWFT          = 1,
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 1024,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input wire logic clk,
    input wire logic rst,
    fifo_level_if.slave bus
);

    localparam int         CW   = CNT_W(DEPTH);
    localparam int         PW   = PTR_W(DEPTH);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    if (WIDTH < 1 || DEPTH < 2) begin : g_bad_size
        $error("fifo_level: WIDTH must be >= 1 and DEPTH >= 2");
    end
    if (AFULL_THRESH < 0 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("fifo_level: AFULL_THRESH outside 0..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH) begin : g_bad_aempty
        $error("fifo_level: AEMPTY_THRESH outside 0..DEPTH");
    end

    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             wr_acc;
    logic             rd_acc;
    logic             overflow;
    logic             underflow;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             mem_we;
    logic             mem_re;
    logic [WIDTH-1:0] mem_dout;

    // Flags derive only from registered state, never from wr/rd.
    assign full   = (count == CW'(DEPTH));
    assign wr_acc = bus.wr & ~full;
    assign rd_acc = bus.rd & ~empty;

    // Occupancy: words accepted minus words popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (wr_acc && !rd_acc) begin
            count <= count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count <= count - CW'(1);
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (bus.wr && full)   overflow  <= 1'b1;
            if (bus.rd && empty)  underflow <= 1'b1;
        end
    end

    // Memory pointers advance only when the RAM itself is written or read.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (mem_we) wr_ptr <= PW'(ptr_inc(32'(wr_ptr), DEPTH));
            if (mem_re) rd_ptr <= PW'(ptr_inc(32'(rd_ptr), DEPTH));
        end
    end

    bram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_bram (
        .clk    (clk),
        .rst    (rst),
        .we_a   (mem_we),
        .addr_a (wr_ptr),
        .din_a  (bus.din),
        .en_b   (mem_re),
        .addr_b (rd_ptr),
        .dout_b (mem_dout)
    );

    if (MODE == FIFO_FWFT) begin : g_fwft
        // The head word always lives in the output stage, either in the
        // bypass register or in the RAM read register; the RAM holds the rest.
        logic             out_valid;
        logic             sel_byp;
        logic [WIDTH-1:0] byp_data;
        logic             mem_empty;
        logic             to_byp;

        assign mem_empty = (count == CW'(out_valid));
        assign to_byp    = wr_acc & (~out_valid | (rd_acc & mem_empty));
        assign mem_we    = wr_acc & ~to_byp;
        assign mem_re    = rd_acc & ~mem_empty;
        assign empty     = ~out_valid;

        // Output stage: bypass a write that becomes head, else refill from RAM.
        always_ff @(posedge clk) begin
            if (rst) begin
                out_valid <= 1'b0;
                sel_byp   <= 1'b1;
                byp_data  <= '0;
            end else if (to_byp) begin
                out_valid <= 1'b1;
                sel_byp   <= 1'b1;
                byp_data  <= bus.din;
            end else if (mem_re) begin
                sel_byp   <= 1'b0;
            end else if (rd_acc) begin
                out_valid <= 1'b0;
            end
        end

        assign bus.dout = sel_byp ? byp_data : mem_dout;
        assign bus.dvld = out_valid;
    end else begin : g_std
        logic dvld;

        assign empty  = (count == '0);
        assign mem_we = wr_acc;
        assign mem_re = rd_acc;

        // Read-data valid pulses in the cycle after an accepted read.
        always_ff @(posedge clk) begin
            if (rst) begin
                dvld <= 1'b0;
            end else begin
                dvld <= rd_acc;
            end
        end

        assign bus.dout = mem_dout;
        assign bus.dvld = dvld;
    end

    assign bus.count        = count;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count >= CW'(AFULL_THRESH));
    assign bus.almost_empty = (count <= CW'(AEMPTY_THRESH));
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_level.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_level
//  Purpose  : Self-checking bench: an FWFT and a standard-mode fifo_level
//             driven by identical stimulus, compared against a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_level;

    localparam int DEPTH  = 5;
    localparam int WIDTH  = 8;
    localparam int AFULL  = 4;
    localparam int AEMPTY = 1;

    logic             clk;
    logic             rst;
    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] din;

    int n_tests;
    int n_fail;

    fifo_level_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_f ();
    fifo_level_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_s ();

    assign bus_f.wr  = wr;
    assign bus_f.rd  = rd;
    assign bus_f.din = din;
    assign bus_s.wr  = wr;
    assign bus_s.rd  = rd;
    assign bus_s.din = din;

    fifo_level #(
        .FWFT(1), .WIDTH(WIDTH), .DEPTH(DEPTH),
        .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
    ) u_fwft (
        .clk (clk),
        .rst (rst),
        .bus (bus_f)
    );

    fifo_level #(
        .FWFT(0), .WIDTH(WIDTH), .DEPTH(DEPTH),
        .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
    ) u_std (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: contents as a queue, plus flags and standard-mode read data.
    logic [WIDTH-1:0] q[$];
    bit               m_ovf;
    bit               m_unf;
    bit               m_sdvld;
    logic [WIDTH-1:0] m_sdout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all(input bit was_rst);
        int n;
        n = q.size();
        check("count_fwft", 32'(bus_f.count), 32'(n));
        check("count_std",  32'(bus_s.count), 32'(n));
        check("full_fwft",  32'(bus_f.full),  32'(n == DEPTH));
        check("full_std",   32'(bus_s.full),  32'(n == DEPTH));
        check("empty_fwft", 32'(bus_f.empty), 32'(n == 0));
        check("empty_std",  32'(bus_s.empty), 32'(n == 0));
        check("afull_fwft", 32'(bus_f.almost_full),  32'(n >= AFULL));
        check("afull_std",  32'(bus_s.almost_full),  32'(n >= AFULL));
        check("aempty_fwft", 32'(bus_f.almost_empty), 32'(n <= AEMPTY));
        check("aempty_std",  32'(bus_s.almost_empty), 32'(n <= AEMPTY));
        check("ovf_fwft", 32'(bus_f.overflow),  32'(m_ovf));
        check("ovf_std",  32'(bus_s.overflow),  32'(m_ovf));
        check("unf_fwft", 32'(bus_f.underflow), 32'(m_unf));
        check("unf_std",  32'(bus_s.underflow), 32'(m_unf));
        check("dvld_fwft", 32'(bus_f.dvld), 32'(n != 0));
        if (n != 0) begin
            check("dout_fwft", 32'(bus_f.dout), 32'(q[0]));
        end
        if (was_rst) begin
            check("dout_fwft_rst", 32'(bus_f.dout), 32'd0);
        end
        check("dvld_std", 32'(bus_s.dvld), 32'(m_sdvld));
        check("dout_std", 32'(bus_s.dout), 32'(m_sdout));
    endtask

    // One clock: drive inputs, advance the model on the edge, check after it.
    task automatic step(input bit w, input bit r, input bit rs);
        bit wa;
        bit ra;
        wr  = w;
        rd  = r;
        rst = rs;
        din = WIDTH'($urandom);
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_sdvld = 1'b0;
            m_sdout = '0;
        end else begin
            wa = w && (q.size() < DEPTH);
            ra = r && (q.size() > 0);
            if (w && !wa) m_ovf = 1'b1;
            if (r && !ra) m_unf = 1'b1;
            m_sdvld = ra;
            if (ra) m_sdout = q.pop_front();
            if (wa) q.push_back(din);
        end
        #1;
        check_all(rs);
    endtask

    initial begin
        int pw;
        int pr;
        n_tests = 0;
        n_fail  = 0;
        wr  = 1'b0;
        rd  = 1'b0;
        rst = 1'b1;
        din = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_sdvld = 1'b0;
        m_sdout = '0;

        // Reset values.
        step(0, 0, 1);
        step(0, 0, 1);

        // Fill to full, one overflowing write, drain, one underflowing read.
        for (int i = 0; i < 6; i++) step(1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0);
        step(0, 0, 1);

        // Single write into empty FIFO, then pop.
        step(1, 0, 0);
        step(0, 1, 0);

        // Steady simultaneous write+read at count 2 across pointer wraps.
        step(1, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 0);

        // Full with write+read: read wins, write rejected.
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        step(1, 1, 0);

        // Empty with write+read: write wins, read rejected.
        step(0, 0, 1);
        step(1, 1, 0);

        // Reset with contents and sticky flag set; inputs during reset ignored.
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 1);
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 1, 0);

        // Randomized traffic with changing write/read bias and rare resets.
        for (int blk = 0; blk < 30; blk++) begin
            pw = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 50 : 80);
            pr = (blk % 5 < 2) ? 80 : ((blk % 5 < 4) ? 50 : 20);
            for (int c = 0; c < 100; c++) begin
                step($urandom_range(99) < pw,
                     $urandom_range(99) < pr,
                     $urandom_range(299) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
